// File: rtl/seq_divider16_if.sv
// Start/done handshake bundle for the iterative divider.
// The ALU side drives through master; the divider sits on slave.
interface seq_divider16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// Unsigned restoring divider, one quotient bit per clock over a WIDTH+1-bit subtract path.
//   state  | meaning
//   S_IDLE | waiting for start; operands latched on accept
//   S_CALC | one shift/subtract iteration per edge, WIDTH iterations
//   S_DONE | results valid, done pulses for this single cycle
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider16_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dv_q;
  logic [WIDTH:0]   r_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   t_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] dq_d;
  logic             last_d;

  // Sign of the trial subtraction alone picks the quotient bit; restore on negative.
  always_comb begin
    t_d    = {r_q[WIDTH-1:0], dq_q[WIDTH-1]};
    diff_d = t_d - {1'b0, dv_q};
    r_d    = t_d;
    dq_d   = {dq_q[WIDTH-2:0], 1'b0};
    if (!diff_d[WIDTH]) begin
      r_d  = diff_d;
      dq_d = {dq_q[WIDTH-2:0], 1'b1};
    end
    last_d = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      dv_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dq_q   <= bus.dividend;
            dv_q   <= bus.divisor;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= bus.dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dq_q  <= dq_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            quot_q  <= dq_d;
            rem_q   <= r_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed bench for seq_divider16: hand-computed results, latency, handshake and reset cases.
module tb_seq_divider16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_divider16_if #(.WIDTH(16)) bus ();

  seq_divider16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: accept, scramble operands, measure edges to done, check results.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ez, input int elat, input string tag);
    int n;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'h5A5A;
    bus.divisor  = 16'h0003;
    @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int ndone;
    int last_idx;
    int gaps_bad;
    int consec;
    logic prev_done;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quot", 32'(bus.quotient), 32'd0);
    chk("rst_rem", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, "d100_7");
    run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16, "dmax_1");
    run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16, "dmax_max");
    run_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 16, "d3_10");
    run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0, "d5_0");
    run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 16, "d9_3");

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd10;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 4) begin
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        chk("busy_ign_quot", 32'(bus.quotient), 32'd100);
        chk("busy_ign_rem", 32'(bus.remainder), 32'd0);
      end
    end
    bus.start = 1'b0;
    chk("busy_ign_ndone", 32'(ndone), 32'd1);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.dividend = 16'd200;
    bus.divisor  = 16'd9;
    bus.start    = 1'b1;
    @(posedge clk);
    ndone     = 0;
    last_idx  = -1;
    gaps_bad  = 0;
    consec    = 0;
    prev_done = 1'b0;
    for (int i = 0; i <= 52; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        chk("b2b_quot", 32'(bus.quotient), 32'd22);
        chk("b2b_rem", 32'(bus.remainder), 32'd2);
        if (last_idx >= 0 && (i - last_idx) != 18) gaps_bad++;
        if (last_idx < 0 && i != 16) gaps_bad++;
        last_idx = i;
        if (prev_done) consec++;
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd3);
    chk("b2b_gaps", 32'(gaps_bad), 32'd0);
    chk("b2b_consec", 32'(consec), 32'd0);
    repeat (3) @(negedge clk);

    // Reset in the middle of CALC.
    @(negedge clk);
    bus.dividend = 16'd60000;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_quot", 32'(bus.quotient), 32'd0);
    chk("mrst_rem", 32'(bus.remainder), 32'd0);
    chk("mrst_dbz", 32'(bus.div_by_zero), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);
    rst_n = 1'b1;
    run_op(16'd60000, 16'd7, 16'd8571, 16'd3, 1'b0, 16, "d60000_7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
